// File: rtl/ioblock_cfg_pkg.sv
// Shared constants for the IOB configuration loader: controller state codes,
// frame geometry and the TSMUX output codes.
package ioblock_cfg_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_COMMIT = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    // Frame layout, first bit first: TSMUX[1], TSMUX[0], DORREG, odd parity
    localparam int unsigned FRAME_BITS = 4;

    localparam logic [1:0] TS_OFF       = 2'b00;
    localparam logic [1:0] TS_CTRL      = 2'b01;
    localparam logic [1:0] TS_DRIVE     = 2'b10;
    localparam logic [1:0] TS_DRIVE_ALT = 2'b11;

endpackage

// File: rtl/ioblock_cfg_frame.sv
// Per-IOB frame deserialiser: shifts in one frame, flags odd-parity pass/fail
// on the cycle its last bit is accepted and presents the decoded fields.
module ioblock_cfg_frame
    import ioblock_cfg_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_bit_en,
    input  logic       i_bit,
    output logic       o_frame_ok,
    output logic       o_frame_bad,
    output logic [1:0] o_tsmux,
    output logic       o_dorreg
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS);

    logic [CNT_W-1:0]      r_bit_cnt;
    logic [FRAME_BITS-2:0] r_frame;
    logic                  w_last;
    logic                  w_par;

    // Fields come straight from the held bits; the parity bit is never stored
    assign w_last      = i_bit_en && (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign w_par       = ^{r_frame, i_bit};
    assign o_frame_ok  = w_last && w_par;
    assign o_frame_bad = w_last && !w_par;
    assign o_tsmux     = r_frame[2:1];
    assign o_dorreg    = r_frame[0];

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_bit_cnt <= '0;
            r_frame   <= '0;
        end else if (i_bit_en) begin
            r_frame   <= {r_frame[FRAME_BITS-3:0], i_bit};
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ioblock_cfg_ctrl.sv
// IOB array configuration loader: sequences frame loads into a shadow copy and
// commits the whole array atomically once every frame has passed parity.
module ioblock_cfg_ctrl
    import ioblock_cfg_pkg::*;
#(
    parameter int unsigned NUM_IOB = 8
) (
    input  logic                 IOCLK,
    input  logic                 RST,
    input  logic                 CFG_START,
    input  logic                 CFG_VALID,
    input  logic                 CFG_DATA,
    output logic                 CFG_READY,
    output logic                 CFG_BUSY,
    output logic                 CFG_DONE,
    output logic                 CFG_ERR,
    output logic [2*NUM_IOB-1:0] TSMUX_OUT,
    output logic [NUM_IOB-1:0]   DORREG_OUT
);

    localparam int unsigned IW = (NUM_IOB > 1) ? $clog2(NUM_IOB) : 1;

    logic [2:0]           r_state;
    logic [IW-1:0]        r_iob_cnt;
    logic [2*NUM_IOB-1:0] r_sh_ts;
    logic [NUM_IOB-1:0]   r_sh_dor;
    logic [2*NUM_IOB-1:0] r_ts;
    logic [NUM_IOB-1:0]   r_dor;

    logic       w_load;
    logic       w_start_ok;
    logic       w_bit_en;
    logic       w_frame_ok;
    logic       w_frame_bad;
    logic [1:0] w_ts;
    logic       w_dor;

    // START outranks a bit offered in the same cycle, even though READY is high
    assign w_load     = (r_state == ST_LOAD);
    assign w_start_ok = CFG_START && (r_state != ST_COMMIT);
    assign w_bit_en   = w_load && CFG_VALID && !CFG_START;

    assign CFG_READY  = w_load;
    assign CFG_BUSY   = w_load || (r_state == ST_COMMIT);
    assign CFG_DONE   = (r_state == ST_DONE);
    assign CFG_ERR    = (r_state == ST_ERR);
    assign TSMUX_OUT  = r_ts;
    assign DORREG_OUT = r_dor;

    ioblock_cfg_frame u_frame (
        .i_clk       (IOCLK),
        .i_rst       (RST),
        .i_clr       (w_start_ok),
        .i_bit_en    (w_bit_en),
        .i_bit       (CFG_DATA),
        .o_frame_ok  (w_frame_ok),
        .o_frame_bad (w_frame_bad),
        .o_tsmux     (w_ts),
        .o_dorreg    (w_dor)
    );

    always_ff @(posedge IOCLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_iob_cnt <= '0;
            r_sh_ts   <= '0;
            r_sh_dor  <= '0;
            r_ts      <= '0;
            r_dor     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (CFG_START) begin
                        r_state   <= ST_LOAD;
                        r_iob_cnt <= '0;
                        r_sh_ts   <= '0;
                        r_sh_dor  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (CFG_START) begin
                        r_iob_cnt <= '0;
                        r_sh_ts   <= '0;
                        r_sh_dor  <= '0;
                    end else if (w_frame_bad) begin
                        r_state <= ST_ERR;
                    end else if (w_frame_ok) begin
                        for (int unsigned i = 0; i < NUM_IOB; i++) begin
                            if (r_iob_cnt == IW'(i)) begin
                                r_sh_ts[2*i +: 2] <= w_ts;
                                r_sh_dor[i]       <= w_dor;
                            end
                        end
                        if (r_iob_cnt == IW'(NUM_IOB - 1))
                            r_state <= ST_COMMIT;
                        else
                            r_iob_cnt <= r_iob_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    r_ts    <= r_sh_ts;
                    r_dor   <= r_sh_dor;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ioblock_cfg_ctrl.sv
// Directed bench for ioblock_cfg_ctrl (NUM_IOB=2) with a bit-list reference model
// compared every cycle, plus hand-computed checkpoints.
module tb_ioblock_cfg_ctrl;

    localparam int N = 2;
    localparam int MI = 0, ML = 1, MC = 2, MD = 3, ME = 4;

    logic           IOCLK = 1'b0;
    logic           RST, CFG_START, CFG_VALID, CFG_DATA;
    logic           CFG_READY, CFG_BUSY, CFG_DONE, CFG_ERR;
    logic [2*N-1:0] TSMUX_OUT;
    logic [N-1:0]   DORREG_OUT;

    int n_tests = 0;
    int n_fail  = 0;

    int             m_mode  = MI;
    int             m_n;
    bit             m_bits[$];
    logic [2*N-1:0] m_ts    = '0;
    logic [N-1:0]   m_dor   = '0;
    bit             m_armed = 1'b0;

    always #5 IOCLK = ~IOCLK;

    ioblock_cfg_ctrl #(.NUM_IOB(N)) dut (
        .IOCLK      (IOCLK),
        .RST        (RST),
        .CFG_START  (CFG_START),
        .CFG_VALID  (CFG_VALID),
        .CFG_DATA   (CFG_DATA),
        .CFG_READY  (CFG_READY),
        .CFG_BUSY   (CFG_BUSY),
        .CFG_DONE   (CFG_DONE),
        .CFG_ERR    (CFG_ERR),
        .TSMUX_OUT  (TSMUX_OUT),
        .DORREG_OUT (DORREG_OUT)
    );

    // Reference: the list of bits accepted since the last START, decoded at commit
    always @(posedge IOCLK) begin
        if (RST) begin
            m_mode = MI;
            m_bits.delete();
            m_ts   = '0;
            m_dor  = '0;
        end else begin
            case (m_mode)
                ML: begin
                    if (CFG_START) begin
                        m_bits.delete();
                    end else if (CFG_VALID) begin
                        m_bits.push_back(CFG_DATA);
                        m_n = m_bits.size();
                        if (m_n % 4 == 0) begin
                            if ((m_bits[m_n-4] ^ m_bits[m_n-3] ^ m_bits[m_n-2] ^ m_bits[m_n-1]) == 1'b0)
                                m_mode = ME;
                            else if (m_n == 4 * N)
                                m_mode = MC;
                        end
                    end
                end
                MC: begin
                    for (int i = 0; i < N; i++) begin
                        m_ts[2*i+1] = m_bits[4*i];
                        m_ts[2*i]   = m_bits[4*i+1];
                        m_dor[i]    = m_bits[4*i+2];
                    end
                    m_mode = MD;
                end
                default: begin
                    if (CFG_START) begin
                        m_mode = ML;
                        m_bits.delete();
                    end
                end
            endcase
        end
    end

    always @(negedge IOCLK) begin
        if (m_armed) begin
            n_tests++;
            if ({CFG_READY, CFG_BUSY, CFG_DONE, CFG_ERR, TSMUX_OUT, DORREG_OUT} !==
                {m_mode == ML, (m_mode == ML) || (m_mode == MC), m_mode == MD, m_mode == ME, m_ts, m_dor}) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got rdy/bsy/dn/er=%b%b%b%b ts=%b dor=%b, want %b%b%b%b ts=%b dor=%b",
                         $time, CFG_READY, CFG_BUSY, CFG_DONE, CFG_ERR, TSMUX_OUT, DORREG_OUT,
                         m_mode == ML, (m_mode == ML) || (m_mode == MC), m_mode == MD, m_mode == ME, m_ts, m_dor);
            end
        end
    end

    task automatic drive(input logic r, input logic s, input logic v, input logic d);
        RST       = r;
        CFG_START = s;
        CFG_VALID = v;
        CFG_DATA  = d;
        @(negedge IOCLK);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input bit gap);
        for (int k = 0; k < n; k++) begin
            if (gap) begin
                chk("gap_ready", 32'(CFG_READY), 32'd1);
                drive(1'b0, 1'b0, 1'b0, 1'($urandom));
            end
            drive(1'b0, 1'b0, 1'b1, bits[n-1-k]);
        end
    endtask

    task automatic wait_end();
        for (int i = 0; i < 10; i++) begin
            if (CFG_DONE || CFG_ERR) break;
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("wait_end", 32'(CFG_DONE || CFG_ERR), 32'd1);
    endtask

    initial begin
        RST = 1'b1; CFG_START = 1'b0; CFG_VALID = 1'b0; CFG_DATA = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        m_armed = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_ts",    32'(TSMUX_OUT),  32'd0);
        chk("rst_dor",   32'(DORREG_OUT), 32'd0);
        chk("rst_ready", 32'(CFG_READY),  32'd0);
        chk("rst_flags", 32'({CFG_BUSY, CFG_DONE, CFG_ERR}), 32'd0);

        // Two good frames back to back
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(16'b1000_0111, 8, 1'b0);
        wait_end();
        chk("t1_ts",   32'(TSMUX_OUT),  32'b0110);
        chk("t1_dor",  32'(DORREG_OUT), 32'b10);
        chk("t1_done", 32'(CFG_DONE),   32'd1);
        chk("t1_err",  32'(CFG_ERR),    32'd0);

        // Bad parity on the first frame keeps the committed config
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(16'b1100, 4, 1'b0);
        chk("t2_err",   32'(CFG_ERR),    32'd1);
        chk("t2_ts",    32'(TSMUX_OUT),  32'b0110);
        chk("t2_dor",   32'(DORREG_OUT), 32'b10);
        chk("t2_ready", 32'(CFG_READY),  32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t2_ready_hold", 32'(CFG_READY), 32'd0);
        chk("t2_busy",       32'(CFG_BUSY),  32'd0);

        // Restart after five bits; bit offered alongside START is dropped
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(16'b10001, 5, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        send_bits(16'b0010_0001, 8, 1'b0);
        wait_end();
        chk("t4_ts",   32'(TSMUX_OUT),  32'd0);
        chk("t4_dor",  32'(DORREG_OUT), 32'b01);
        chk("t4_done", 32'(CFG_DONE),   32'd1);

        // VALID toggling every cycle
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(16'b1000_0111, 8, 1'b1);
        wait_end();
        chk("t3_ts",   32'(TSMUX_OUT),  32'b0110);
        chk("t3_dor",  32'(DORREG_OUT), 32'b10);
        chk("t3_done", 32'(CFG_DONE),   32'd1);

        // Reset on the third bit of a load
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(16'b01, 2, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t5_ts",    32'(TSMUX_OUT),  32'd0);
        chk("t5_dor",   32'(DORREG_OUT), 32'd0);
        chk("t5_ready", 32'(CFG_READY),  32'd0);
        chk("t5_flags", 32'({CFG_BUSY, CFG_DONE, CFG_ERR}), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Traffic in DONE without START is ignored
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(16'b1000_0111, 8, 1'b0);
        wait_end();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'($urandom));
            chk("t6_ready", 32'(CFG_READY),  32'd0);
            chk("t6_ts",    32'(TSMUX_OUT),  32'b0110);
            chk("t6_dor",   32'(DORREG_OUT), 32'b10);
            chk("t6_done",  32'(CFG_DONE),   32'd1);
        end

        m_armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
